adc_pulse_monitor: RTL and testbench
====================================

Name: adc_pulse_monitor

Overview:
- Sits directly downstream of adc_control, in parallel with limit_check.
- Consumes the serial ADC converter's data_valid/data stream, gated by laser_pulse.
- Tracks per-pulse peak drive-current samples and compares them against the monitor current limits (pulsed or CW).
- Drives the sticky monitor over-current fault and the 8-bit monitor_status byte read back over I2C.

Parameters:
- DATA_W, 16: ADC sample width.
- SETTLE_SAMPLES, 2: valid samples discarded after each pulse rising edge (turn-on transient).
- FAIL_COUNT, 3: consecutive over-limit evaluations required to latch the fault; range 1..15.
- CNT_W, 16: width of the per-pulse sample counter.

Ports:
- clk  in  1  system clock (clk_div2 domain).
- rstn  in  1  synchronous reset, active-high (1 = reset).
- clear_fail  in  1  level; clears the sticky fault and consecutive counter while high.
- enable  in  1  0 = monitor idle, no evaluation.
- pulse_cw_select  in  1  0 = pulsed mode (pwm limit), 1 = CW mode (cw limit).
- laser_pulse  in  1  asynchronous laser gate input.
- adc_data_valid  in  1  1-cycle strobe per ADC sample.
- adc_data  in  DATA_W  sample; valid only with adc_data_valid.
- pwm_mon_current_limit  in  16  pulsed-mode peak limit.
- cw_mon_current_limit  in  16  CW-mode limit.
- peak_value  out  DATA_W  peak of last completed window.
- sample_count  out  CNT_W  samples accumulated in last completed window.
- pulse_done  out  1  1-cycle strobe when a window is evaluated.
- over_limit_fail  out  1  sticky fault.
- monitor_status  out  8  {over_limit_fail, state[1:0], fail_cnt[3:0] saturated, enable}.

Behaviour:
- Reset (rstn = 1 at a clk edge): all outputs 0; state IDLE; synchronizer flops 0; peak accumulator 0; counters 0. Reset mid-window discards the window with no pulse_done.
- laser_pulse: 2-flop synchronizer, then a rising/falling edge detect on the synced value. The edge is seen 3 clk after the pin toggle.
- States: IDLE -> SETTLE -> ACQUIRE -> EVAL -> IDLE.
- IDLE:
  - Pulsed mode: a rising edge with enable = 1 goes to SETTLE; the settle counter and peak accumulator clear to 0.
  - CW mode: goes directly to ACQUIRE, one window per sample (see CW below).
- SETTLE: counts adc_data_valid strobes; after SETTLE_SAMPLES strobes, go to ACQUIRE. Falling edge during SETTLE goes to IDLE with no evaluation and no pulse_done.
- ACQUIRE (pulsed):
  - Each valid sample: peak_acc = max(peak_acc, adc_data), unsigned compare.
  - sample_acc increments and saturates at all-ones, no wrap.
  - Falling edge goes to EVAL. A valid strobe coincident with the falling edge is included.
- CW mode (pulse_cw_select = 1):
  - Each valid sample while enable = 1 is its own window: peak = the sample, count = 1.
  - EVAL occurs the cycle after the strobe.
  - laser_pulse is ignored.
- EVAL (single cycle):
  - Outputs update: peak_value <= peak_acc and sample_count <= sample_acc; pulse_done = 1 this cycle.
  - Over-limit = peak_acc > selected limit (strictly greater; equal passes).
  - Over-limit increments fail_cnt (saturates at 15); not over-limit resets fail_cnt to 0.
  - When the incremented fail_cnt >= FAIL_COUNT, over_limit_fail <= 1 (sticky).
  - A window with sample_acc = 0 counts as not over-limit and still strobes pulse_done.
- Sticky fault: over_limit_fail is cleared only by clear_fail = 1 or reset.
  - clear_fail has priority over a simultaneous EVAL set: the fault stays 0 and fail_cnt = 0.
  - Evaluation continues while clear_fail is held, but nothing latches.
- enable dropping to 0 in any state: go to IDLE at the next edge and discard the in-progress window. The latched fault and output registers are retained.
- Mode change mid-window: pulse_cw_select is sampled at IDLE exit and held for the window.
- Latency: from the last pulse falling pin edge to pulse_done is at most 5 clk.

Test Plan:
- Reset with data streaming -> all outputs 0, no pulse_done while rstn = 1; first window after release evaluates normally.
- Pulsed mode, SETTLE_SAMPLES = 2, pwm limit 0x4000, samples 0x7000, 0x6000, 0x1000, 0x3FFF, 0x2000, then pulse low -> first two discarded; peak_value = 0x3FFF, sample_count = 3, pulse_done once, fail_cnt = 0.
- Three consecutive pulses with peak 0x4001 (limit 0x4000, FAIL_COUNT = 3) -> fail_cnt 1, 2, 3; over_limit_fail rises at the third EVAL. A pulse with peak exactly 0x4000 in between resets fail_cnt to 0 and no fault latches.
- Fault latched, then clear_fail pulsed for 1 clk coincident with an over-limit EVAL -> over_limit_fail = 0 and fail_cnt = 0 afterwards; the next over-limit pulse gives fail_cnt = 1.
- CW mode, cw limit 0x1000, samples 0x0FFF, 0x1001 x3 -> pulse_done strobes 1 clk after each valid; fault latches on the 4th sample; peak_value = 0x1001, sample_count = 1.
- Pulse shorter than settle (falls after 1 sample), and enable dropped mid-ACQUIRE -> no pulse_done; previous peak_value and sample_count unchanged; state returns to IDLE (monitor_status[6:5] = 0).

Source files
------------

// File: rtl/adc_pulse_monitor.sv
// Per-pulse peak current monitor on the ADC sample stream: tracks the window peak,
// compares it against the pulsed/CW limit and latches a sticky over-current fault.
module adc_pulse_monitor #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned SETTLE_SAMPLES = 2,
    parameter int unsigned FAIL_COUNT     = 3,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear_fail,
    input  logic              enable,
    input  logic              pulse_cw_select,
    input  logic              laser_pulse,
    input  logic              adc_data_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [15:0]       pwm_mon_current_limit,
    input  logic [15:0]       cw_mon_current_limit,
    output logic [DATA_W-1:0] peak_value,
    output logic [CNT_W-1:0]  sample_count,
    output logic              pulse_done,
    output logic              over_limit_fail,
    output logic [7:0]        monitor_status
);

    localparam int unsigned CMP_W    = (DATA_W > 16) ? DATA_W : 16;
    localparam int unsigned SET_W    = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam int unsigned SET_LAST = (SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1;
    localparam logic [3:0]  FAIL_TH  = 4'(FAIL_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ACQUIRE = 2'd2,
        EVAL    = 2'd3
    } state_t;

    state_t            state_q;
    logic              mode_q;
    logic [2:0]        sync_q;
    logic [SET_W-1:0]  settle_cnt_q;
    logic [DATA_W-1:0] peak_acc_q;
    logic [CNT_W-1:0]  sample_acc_q;
    logic [DATA_W-1:0] peak_value_q;
    logic [CNT_W-1:0]  sample_count_q;
    logic              pulse_done_q;
    logic              fault_q;
    logic [3:0]        fail_cnt_q;
    logic              enable_q;

    logic              rise;
    logic              fall;
    logic [DATA_W-1:0] peak_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              cw_path;
    logic [DATA_W-1:0] win_peak_d;
    logic [CNT_W-1:0]  win_cnt_d;
    logic [15:0]       limit_d;
    logic              over_d;
    logic [3:0]        fail_inc_d;
    logic              eval_d;

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

    always_comb begin
        peak_d = peak_acc_q;
        if (adc_data_valid && (adc_data > peak_acc_q))
            peak_d = adc_data;
        cnt_d = sample_acc_q;
        if (adc_data_valid && (sample_acc_q != '1))
            cnt_d = sample_acc_q + CNT_W'(1);

        // Evaluation happens on the transition into EVAL, so the closing window
        // (including a strobe coincident with the falling edge) is judged here.
        cw_path    = (state_q == IDLE) || mode_q;
        win_peak_d = cw_path ? adc_data : peak_d;
        win_cnt_d  = cw_path ? CNT_W'(1) : cnt_d;
        limit_d    = cw_path ? cw_mon_current_limit : pwm_mon_current_limit;
        over_d     = (win_cnt_d != '0) && (CMP_W'(win_peak_d) > CMP_W'(limit_d));
        fail_inc_d = (fail_cnt_q == 4'hF) ? 4'hF : fail_cnt_q + 4'd1;

        eval_d = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE:    eval_d = pulse_cw_select && adc_data_valid;
                ACQUIRE: eval_d = mode_q ? adc_data_valid : fall;
                default: eval_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q        <= IDLE;
            mode_q         <= 1'b0;
            sync_q         <= '0;
            settle_cnt_q   <= '0;
            peak_acc_q     <= '0;
            sample_acc_q   <= '0;
            peak_value_q   <= '0;
            sample_count_q <= '0;
            pulse_done_q   <= 1'b0;
            fault_q        <= 1'b0;
            fail_cnt_q     <= '0;
            enable_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[1:0], laser_pulse};
            enable_q     <= enable;
            pulse_done_q <= 1'b0;

            if (eval_d) begin
                peak_value_q   <= win_peak_d;
                sample_count_q <= win_cnt_d;
                pulse_done_q   <= 1'b1;
                fail_cnt_q     <= over_d ? fail_inc_d : 4'd0;
                if (over_d && (fail_inc_d >= FAIL_TH))
                    fault_q <= 1'b1;
            end

            if (clear_fail) begin
                fault_q    <= 1'b0;
                fail_cnt_q <= '0;
            end

            if (!enable) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        mode_q       <= pulse_cw_select;
                        settle_cnt_q <= '0;
                        peak_acc_q   <= '0;
                        sample_acc_q <= '0;
                        if (pulse_cw_select)
                            state_q <= eval_d ? EVAL : ACQUIRE;
                        else if (rise)
                            state_q <= (SETTLE_SAMPLES == 0) ? ACQUIRE : SETTLE;
                    end
                    SETTLE: begin
                        if (fall) begin
                            state_q <= IDLE;
                        end else if (adc_data_valid) begin
                            if (settle_cnt_q == SET_W'(SET_LAST))
                                state_q <= ACQUIRE;
                            else
                                settle_cnt_q <= settle_cnt_q + SET_W'(1);
                        end
                    end
                    ACQUIRE: begin
                        if (mode_q) begin
                            // CW waits here between single-sample windows; leaving CW
                            // returns through IDLE so the new mode is sampled there.
                            if (eval_d)
                                state_q <= EVAL;
                            else if (!pulse_cw_select)
                                state_q <= IDLE;
                        end else begin
                            peak_acc_q   <= peak_d;
                            sample_acc_q <= cnt_d;
                            if (fall)
                                state_q <= EVAL;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign peak_value      = peak_value_q;
    assign sample_count    = sample_count_q;
    assign pulse_done      = pulse_done_q;
    assign over_limit_fail = fault_q;
    assign monitor_status  = {fault_q, state_q, fail_cnt_q, enable_q};

endmodule

// File: tb/tb_adc_pulse_monitor.sv
// Directed bench for adc_pulse_monitor: a table of pulsed windows plus hand
// sequences for reset, clear/EVAL collision, CW mode, short pulse and enable drop.
module tb_adc_pulse_monitor;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clear_fail;
    logic        enable;
    logic        pulse_cw_select;
    logic        laser_pulse;
    logic        adc_data_valid;
    logic [15:0] adc_data;
    logic [15:0] pwm_mon_current_limit;
    logic [15:0] cw_mon_current_limit;
    logic [15:0] peak_value;
    logic [15:0] sample_count;
    logic        pulse_done;
    logic        over_limit_fail;
    logic [7:0]  monitor_status;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    adc_pulse_monitor #(
        .DATA_W(16),
        .SETTLE_SAMPLES(2),
        .FAIL_COUNT(3),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .clear_fail(clear_fail),
        .enable(enable),
        .pulse_cw_select(pulse_cw_select),
        .laser_pulse(laser_pulse),
        .adc_data_valid(adc_data_valid),
        .adc_data(adc_data),
        .pwm_mon_current_limit(pwm_mon_current_limit),
        .cw_mon_current_limit(cw_mon_current_limit),
        .peak_value(peak_value),
        .sample_count(sample_count),
        .pulse_done(pulse_done),
        .over_limit_fail(over_limit_fail),
        .monitor_status(monitor_status)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pulse_done === 1'b1) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0][15:0] s;
        int               n;
        logic [15:0]      peak;
        logic [15:0]      cnt;
        logic [3:0]       fc;
        logic             fault;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_sample(input logic [15:0] v);
        adc_data       = v;
        adc_data_valid = 1'b1;
        tick();
        adc_data_valid = 1'b0;
        tick();
        tick();
    endtask

    function automatic vec_t mk(input logic [15:0] s0, s1, s2, s3, input int n,
                                input logic [15:0] peak, cnt, input logic [3:0] fc,
                                input logic fault);
        vec_t v;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        v.n = n; v.peak = peak; v.cnt = cnt; v.fc = fc; v.fault = fault;
        return v;
    endfunction

    // One pulsed window: two discarded settle samples (0x7000, 0x6000), then the
    // window samples, then the falling pin edge; EVAL lands on the 3rd edge after it.
    task automatic run_window(input vec_t v, input logic clr, input string tag);
        int d0;
        laser_pulse = 1'b1;
        tick(); tick(); tick();
        chk({tag, " settle_state"}, 32'(monitor_status[6:5]), 32'd1);
        send_sample(16'h7000);
        send_sample(16'h6000);
        chk({tag, " acquire_state"}, 32'(monitor_status[6:5]), 32'd2);
        for (int i = 0; i < v.n; i++) send_sample(v.s[i]);
        d0 = done_cnt;
        laser_pulse = 1'b0;
        tick(); tick();
        chk({tag, " no_early_done"}, 32'(pulse_done), 32'd0);
        if (clr) clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        chk({tag, " pulse_done"}, 32'(pulse_done), 32'd1);
        chk({tag, " eval_state"}, 32'(monitor_status[6:5]), 32'd3);
        chk({tag, " peak_value"}, 32'(peak_value), 32'(v.peak));
        chk({tag, " sample_count"}, 32'(sample_count), 32'(v.cnt));
        chk({tag, " fail_cnt"}, 32'(monitor_status[4:1]), 32'(v.fc));
        chk({tag, " fault"}, 32'(over_limit_fail), 32'(v.fault));
        chk({tag, " status_fault"}, 32'(monitor_status[7]), 32'(v.fault));
        tick();
        chk({tag, " done_1cyc"}, 32'(pulse_done), 32'd0);
        chk({tag, " back_idle"}, 32'(monitor_status[6:5]), 32'd0);
        tick();
        chk({tag, " done_once"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int d0;
        rstn = 1'b1; clear_fail = 1'b0; enable = 1'b1; pulse_cw_select = 1'b0;
        laser_pulse = 1'b0; adc_data_valid = 1'b0; adc_data = '0;
        pwm_mon_current_limit = 16'h4000; cw_mon_current_limit = 16'h1000;

        tbl[0] = mk(16'h1000, 16'h3FFF, 16'h2000, 16'h0000, 3, 16'h3FFF, 16'd3, 4'd0, 1'b0);
        tbl[1] = mk(16'h4001, 16'h0100, 16'h0000, 16'h0000, 2, 16'h4001, 16'd2, 4'd1, 1'b0);
        tbl[2] = mk(16'h4001, 16'h0000, 16'h0000, 16'h0000, 1, 16'h4001, 16'd1, 4'd2, 1'b0);
        tbl[3] = mk(16'h4000, 16'h0010, 16'h0000, 16'h0000, 2, 16'h4000, 16'd2, 4'd0, 1'b0);
        tbl[4] = mk(16'h0001, 16'h4001, 16'h0000, 16'h0000, 2, 16'h4001, 16'd2, 4'd1, 1'b0);
        tbl[5] = mk(16'h4001, 16'h4001, 16'h4001, 16'h4001, 4, 16'h4001, 16'd4, 4'd2, 1'b0);
        tbl[6] = mk(16'h4001, 16'h8000, 16'h0000, 16'h0000, 2, 16'h8000, 16'd2, 4'd3, 1'b1);
        tbl[7] = mk(16'h1234, 16'h0000, 16'h0000, 16'h0000, 1, 16'h1234, 16'd1, 4'd0, 1'b1);
        tbl[8] = mk(16'h4001, 16'h0000, 16'h0000, 16'h0000, 1, 16'h4001, 16'd1, 4'd1, 1'b1);

        // Reset held while data and pulse edges stream in
        for (int i = 0; i < 24; i++) begin
            laser_pulse    = (i >= 3 && i < 14);
            adc_data       = 16'hF000 + 16'(i);
            adc_data_valid = i[0];
            tick();
        end
        adc_data_valid = 1'b0;
        laser_pulse    = 1'b0;
        tick();
        chk("rst no_done", 32'(done_cnt), 32'd0);
        chk("rst peak", 32'(peak_value), 32'd0);
        chk("rst count", 32'(sample_count), 32'd0);
        chk("rst fault", 32'(over_limit_fail), 32'd0);
        chk("rst status", 32'(monitor_status), 32'd0);
        rstn = 1'b0;
        tick(); tick(); tick();
        chk("post_rst status", 32'(monitor_status), 32'h01);

        for (int k = 0; k < 9; k++) run_window(tbl[k], 1'b0, $sformatf("tbl%0d", k));

        // Clear coincident with an over-limit EVAL wins, then counting restarts
        run_window(mk(16'h4001, 16'h0, 16'h0, 16'h0, 1, 16'h4001, 16'd1, 4'd0, 1'b0), 1'b1, "clr_eval");
        run_window(mk(16'h4001, 16'h0, 16'h0, 16'h0, 1, 16'h4001, 16'd1, 4'd1, 1'b0), 1'b0, "after_clr");

        // CW mode: each strobe is its own window, evaluated one clock later
        pulse_cw_select = 1'b1;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            logic [15:0] v;
            v = (i == 0) ? 16'h0FFF : 16'h1001;
            adc_data       = v;
            adc_data_valid = 1'b1;
            tick();
            adc_data_valid = 1'b0;
            chk($sformatf("cw%0d pulse_done", i), 32'(pulse_done), 32'd1);
            chk($sformatf("cw%0d peak", i), 32'(peak_value), 32'(v));
            chk($sformatf("cw%0d count", i), 32'(sample_count), 32'd1);
            chk($sformatf("cw%0d fail_cnt", i), 32'(monitor_status[4:1]), 32'(i));
            chk($sformatf("cw%0d fault", i), 32'(over_limit_fail), (i == 3) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("cw%0d done_1cyc", i), 32'(pulse_done), 32'd0);
            tick(); tick();
        end

        // Pulse shorter than the settle period: discarded silently
        pulse_cw_select = 1'b0;
        tick(); tick(); tick();
        d0 = done_cnt;
        laser_pulse = 1'b1;
        tick(); tick(); tick();
        send_sample(16'h7FFF);
        laser_pulse = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("short no_done", 32'(done_cnt - d0), 32'd0);
        chk("short state", 32'(monitor_status[6:5]), 32'd0);
        chk("short peak_kept", 32'(peak_value), 32'h1001);
        chk("short count_kept", 32'(sample_count), 32'd1);

        // Enable dropped mid-ACQUIRE: window discarded, fault and outputs retained
        laser_pulse = 1'b1;
        tick(); tick(); tick();
        send_sample(16'h7000);
        send_sample(16'h6000);
        send_sample(16'h5000);
        enable = 1'b0;
        tick();
        chk("en_drop state", 32'(monitor_status[6:5]), 32'd0);
        chk("en_drop status_en", 32'(monitor_status[0]), 32'd0);
        laser_pulse = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        enable = 1'b1;
        tick(); tick();
        chk("en_drop no_done", 32'(done_cnt - d0), 32'd0);
        chk("en_drop peak_kept", 32'(peak_value), 32'h1001);
        chk("en_drop count_kept", 32'(sample_count), 32'd1);
        chk("en_drop fault_kept", 32'(over_limit_fail), 32'd1);

        // Reset mid-window: no pulse_done, everything back to zero
        laser_pulse = 1'b1;
        tick(); tick(); tick();
        send_sample(16'h7000);
        send_sample(16'h6000);
        send_sample(16'h7777);
        rstn = 1'b1;
        tick(); tick();
        chk("midrst peak", 32'(peak_value), 32'd0);
        chk("midrst count", 32'(sample_count), 32'd0);
        chk("midrst fault", 32'(over_limit_fail), 32'd0);
        chk("midrst status", 32'(monitor_status), 32'd0);
        laser_pulse = 1'b0;
        tick(); tick(); tick();
        rstn = 1'b0;
        tick(); tick(); tick(); tick();
        chk("midrst no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst status_after", 32'(monitor_status), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
